// File: rtl/perf_monitor_pkg.sv
// Shared types for the checkpoint-code performance monitor.
// Holds the channel state encoding and a helper for index widths.
package perf_monitor_pkg;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_RUN_ENC  = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;
  localparam logic [1:0] ST_TOUT_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_RUN  = ST_RUN_ENC,
    ST_DONE = ST_DONE_ENC,
    ST_TOUT = ST_TOUT_ENC
  } state_e;

  // Width needed to index n items, never less than one bit.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_channel.sv
// One measurement channel: start/stop state machine, cycle prescaler
// and saturating elapsed counter with optional timeout.
module perf_channel
  import perf_monitor_pkg::*;
#(
  parameter int CODE_W   = 16,
  parameter int CNT_W    = 32,
  parameter int PRESCALE = 1000,
  parameter int TIMEOUT  = 150
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ev_i,
  input  logic [CODE_W-1:0] code_i,
  input  logic [CODE_W-1:0] start_i,
  input  logic [CODE_W-1:0] stop_i,
  input  logic              enable_i,
  input  logic              clear_i,
  output state_e            state_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int SUB_W = min1_clog2(PRESCALE);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic               hit_start_s, hit_stop_s;

  assign hit_start_s = ev_i && (code_i == start_i);
  assign hit_stop_s  = ev_i && (code_i == stop_i);

  // Channel state, prescaler and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      sub_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sub_q   <= sub_d;
    end
  end

  // Next-state logic; a stop in RUN freezes the count held this cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sub_d   = sub_q;
    if (clear_i || !enable_i) begin
      state_d = ST_IDLE;
      count_d = '0;
      sub_d   = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hit_stop_s) begin
            state_d = ST_DONE;
          end else if (hit_start_s) begin
            count_d = '0;
            sub_d   = '0;
          end else if ((TIMEOUT != 0) && (count_q == CNT_W'(TIMEOUT))) begin
            state_d = ST_TOUT;
          end else if (sub_q == SUB_W'(PRESCALE - 1)) begin
            sub_d   = '0;
            count_d = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
          end else begin
            sub_d = sub_q + SUB_W'(1);
          end
        end
        ST_IDLE, ST_DONE, ST_TOUT: begin
          if (hit_start_s) begin
            state_d = ST_RUN;
            count_d = '0;
            sub_d   = '0;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
          sub_d   = '0;
        end
      endcase
    end
  end

  assign state_o = state_q;
  assign count_o = count_q;

endmodule

// File: rtl/perf_monitor.sv
// Multi-channel checkpoint-code performance monitor: synchronises the
// firmware checkpoint bus, detects code changes and drives per-channel timers.
module perf_monitor
  import perf_monitor_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CODE_W   = 16,
  parameter int CNT_W    = 32,
  parameter int PRESCALE = 1000,
  parameter int TIMEOUT  = 150,
  localparam int SEL_W   = min1_clog2(NUM_CH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [CODE_W-1:0]        checkbits,
  input  logic [NUM_CH-1:0]        cfg_enable,
  input  logic [NUM_CH*CODE_W-1:0] cfg_start_code,
  input  logic [NUM_CH*CODE_W-1:0] cfg_stop_code,
  input  logic                     clear,
  input  logic [SEL_W-1:0]         rd_sel,
  output logic [CNT_W-1:0]         rd_count,
  output logic [1:0]               rd_state,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        done,
  output logic [NUM_CH-1:0]        timeout,
  output logic                     irq
);

  logic [CODE_W-1:0] s1_q, s2_q, prev_q;
  logic              ev_s;
  state_e            ch_state_s [NUM_CH];
  logic [CNT_W-1:0]  ch_count_s [NUM_CH];

  // Two-flop synchroniser for the pad bus plus previous-value register.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= checkbits;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign ev_s = (s2_q != prev_q);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    perf_channel #(
      .CODE_W   (CODE_W),
      .CNT_W    (CNT_W),
      .PRESCALE (PRESCALE),
      .TIMEOUT  (TIMEOUT)
    ) u_ch (
      .clk_i    (clock),
      .rst_i    (reset),
      .ev_i     (ev_s),
      .code_i   (s2_q),
      .start_i  (cfg_start_code[g*CODE_W +: CODE_W]),
      .stop_i   (cfg_stop_code[g*CODE_W +: CODE_W]),
      .enable_i (cfg_enable[g]),
      .clear_i  (clear),
      .state_o  (ch_state_s[g]),
      .count_o  (ch_count_s[g])
    );
  end

  // Per-channel status decode and readback mux; unmatched selects read 0.
  always_comb begin
    busy     = '0;
    done     = '0;
    timeout  = '0;
    rd_count = '0;
    rd_state = ST_IDLE_ENC;
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i]    = (ch_state_s[i] == ST_RUN);
      done[i]    = (ch_state_s[i] == ST_DONE);
      timeout[i] = (ch_state_s[i] == ST_TOUT);
      if (rd_sel == SEL_W'(i)) begin
        rd_count = ch_count_s[i];
        rd_state = ch_state_s[i];
      end else begin
        rd_count = rd_count;
      end
    end
  end

  assign irq = |((done | timeout) & cfg_enable);

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: a default-sized instance plus a small
// 3-channel instance with fast prescale/timeout and an out-of-range select.
module tb_perf_monitor;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] checkbits;
  logic [3:0]  cfg_enable;
  logic [63:0] cfg_start, cfg_stop;
  logic        clear;
  logic [1:0]  rd_sel;

  logic [31:0] rd_count, rd_count_t;
  logic [1:0]  rd_state, rd_state_t;
  logic [3:0]  busy, done, timeout;
  logic [2:0]  busy_t, done_t, timeout_t;
  logic        irq, irq_t;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  perf_monitor dut (
    .clock(clock), .reset(reset), .checkbits(checkbits), .cfg_enable(cfg_enable),
    .cfg_start_code(cfg_start), .cfg_stop_code(cfg_stop), .clear(clear), .rd_sel(rd_sel),
    .rd_count(rd_count), .rd_state(rd_state), .busy(busy), .done(done),
    .timeout(timeout), .irq(irq)
  );

  perf_monitor #(.NUM_CH(3), .PRESCALE(10), .TIMEOUT(3)) dut_to (
    .clock(clock), .reset(reset), .checkbits(checkbits), .cfg_enable(cfg_enable[2:0]),
    .cfg_start_code(cfg_start[47:0]), .cfg_stop_code(cfg_stop[47:0]), .clear(clear),
    .rd_sel(rd_sel), .rd_count(rd_count_t), .rd_state(rd_state_t), .busy(busy_t),
    .done(done_t), .timeout(timeout_t), .irq(irq_t)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; checkbits = 16'h0000; rd_sel = 2'd0;
    cfg_enable = 4'b0001; cfg_start = 64'h0; cfg_stop = 64'h0;
    cfg_start[15:0] = 16'hA000; cfg_stop[15:0] = 16'hAB00;
    cyc(3);
    n_vec++; if ({busy, done, timeout, irq} !== 13'h0) begin n_bad++; $display("FAIL reset_flags got %h exp 0", {busy, done, timeout, irq}); end
    n_vec++; if ({rd_count, rd_state} !== 34'h0) begin n_bad++; $display("FAIL reset_rd got %h exp 0", {rd_count, rd_state}); end
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic test_single();
    checkbits = 16'hA000; cyc(3);
    n_vec++; if (busy !== 4'b0001) begin n_bad++; $display("FAIL single_busy got %b exp 0001", busy); end
    cyc(4997); checkbits = 16'hAB00; cyc(4);
    n_vec++; if (done !== 4'b0001 || busy !== 4'b0000) begin n_bad++; $display("FAIL single_done got done=%b busy=%b exp 0001/0000", done, busy); end
    n_vec++; if (rd_count !== 32'd4) begin n_bad++; $display("FAIL single_count got %0d exp 4", rd_count); end
    n_vec++; if (rd_state !== 2'd2 || irq !== 1'b1) begin n_bad++; $display("FAIL single_state got %0d irq=%b exp 2/1", rd_state, irq); end
  endtask

  task automatic test_timeout();
    checkbits = 16'hA000; cyc(20);
    n_vec++; if (busy_t !== 3'b001 || rd_count_t !== 32'd1) begin n_bad++; $display("FAIL tout_run got busy=%b cnt=%0d exp 001/1", busy_t, rd_count_t); end
    cyc(20);
    n_vec++; if (timeout_t !== 3'b001 || rd_state_t !== 2'd3) begin n_bad++; $display("FAIL tout_flag got %b st=%0d exp 001/3", timeout_t, rd_state_t); end
    n_vec++; if (rd_count_t !== 32'd3 || irq_t !== 1'b1) begin n_bad++; $display("FAIL tout_count got %0d irq=%b exp 3/1", rd_count_t, irq_t); end
    cyc(50);
    n_vec++; if (rd_count_t !== 32'd3) begin n_bad++; $display("FAIL tout_hold got %0d exp 3", rd_count_t); end
    rd_sel = 2'd3; #1;
    n_vec++; if (rd_count_t !== 32'd0 || rd_state_t !== 2'd0) begin n_bad++; $display("FAIL rd_oob got %0d/%0d exp 0/0", rd_count_t, rd_state_t); end
    rd_sel = 2'd0;
  endtask

  task automatic test_restart();
    checkbits = 16'h1111; cyc(2);
    checkbits = 16'hA000; cyc(2500);
    n_vec++; if (busy[0] !== 1'b1 || rd_count !== 32'd2) begin n_bad++; $display("FAIL restart_pre got busy=%b cnt=%0d exp 1/2", busy[0], rd_count); end
    checkbits = 16'h1111; cyc(5);
    checkbits = 16'hA000; cyc(1000);
    checkbits = 16'hAB00; cyc(4);
    n_vec++; if (done[0] !== 1'b1 || rd_count !== 32'd0) begin n_bad++; $display("FAIL restart_count got done=%b cnt=%0d exp 1/0", done[0], rd_count); end
  endtask

  task automatic test_multi();
    cfg_enable = 4'b0011; cfg_start[31:16] = 16'hA000; cfg_stop[31:16] = 16'hAC00;
    checkbits = 16'hA000; cyc(1500);
    checkbits = 16'hAB00; cyc(1200);
    checkbits = 16'hAC00; cyc(4);
    n_vec++; if (done !== 4'b0011 || busy !== 4'b0000) begin n_bad++; $display("FAIL multi_done got %b busy=%b exp 0011/0000", done, busy); end
    rd_sel = 2'd0; #1;
    n_vec++; if (rd_count !== 32'd1) begin n_bad++; $display("FAIL multi_ch0 got %0d exp 1", rd_count); end
    rd_sel = 2'd1; #1;
    n_vec++; if (rd_count !== 32'd2) begin n_bad++; $display("FAIL multi_ch1 got %0d exp 2", rd_count); end
    rd_sel = 2'd0;
  endtask

  task automatic test_clear();
    cfg_enable = 4'b0001;
    checkbits = 16'h0000; cyc(2);
    checkbits = 16'hA000; cyc(10);
    n_vec++; if (busy !== 4'b0001) begin n_bad++; $display("FAIL clear_pre got %b exp 0001", busy); end
    clear = 1'b1; cyc(1); clear = 1'b0;
    n_vec++; if (rd_state !== 2'd0 || rd_count !== 32'd0 || busy !== 4'b0000) begin n_bad++; $display("FAIL clear_idle got st=%0d cnt=%0d busy=%b exp 0/0/0000", rd_state, rd_count, busy); end
    cyc(20);
    n_vec++; if (busy !== 4'b0000) begin n_bad++; $display("FAIL clear_hold got %b exp 0000", busy); end
    checkbits = 16'h0000; cyc(2);
    checkbits = 16'hA000; cyc(3);
    n_vec++; if (busy !== 4'b0001) begin n_bad++; $display("FAIL clear_rearm got %b exp 0001", busy); end
  endtask

  task automatic test_reset_enable();
    reset = 1'b1; cyc(1);
    n_vec++; if ({busy, done, timeout, irq, rd_count, rd_state} !== 47'h0) begin n_bad++; $display("FAIL reset_run got %h exp 0", {busy, done, timeout, irq, rd_count, rd_state}); end
    reset = 1'b0;
    cfg_enable = 4'b0011;
    checkbits = 16'h0000; cyc(2);
    checkbits = 16'hA000; cyc(5);
    checkbits = 16'hAC00; cyc(4);
    n_vec++; if (done !== 4'b0010 || busy !== 4'b0001 || irq !== 1'b1) begin n_bad++; $display("FAIL en_pre got done=%b busy=%b irq=%b exp 0010/0001/1", done, busy, irq); end
    cfg_enable = 4'b0001; cyc(1);
    rd_sel = 2'd1; #1;
    n_vec++; if (done !== 4'b0000 || irq !== 1'b0 || rd_state !== 2'd0) begin n_bad++; $display("FAIL en_drop got done=%b irq=%b st=%0d exp 0000/0/0", done, irq, rd_state); end
    rd_sel = 2'd0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_timeout();
    test_restart();
    test_multi();
    test_clear();
    test_reset_enable();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/perf_monitor.md
Name: perf_monitor

Overview:
Synthesizable, multi-channel successor to the checkpoint-code cycle counter used in SoC performance benches. It watches a 16-bit checkpoint bus driven by firmware on user GPIOs. Each channel has its own start and stop code and measures elapsed time in prescaled units ("kcycles"), with timeout detection. Results are readable on-chip through a select mux, and an interrupt fires when a channel completes.

Parameters:
NUM_CH, 4, number of independent measurement channels (1..16)
CODE_W, 16, checkpoint code width
CNT_W, 32, elapsed-count width (prescaled units)
PRESCALE, 1000, clock cycles per count unit (>=1)
TIMEOUT, 150, count value that forces a timeout; 0 disables timeout

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
checkbits  in  CODE_W  asynchronous checkpoint bus from pads
cfg_enable  in  NUM_CH  per-channel enable
cfg_start_code  in  NUM_CH*CODE_W  start code; channel i uses bits [i*CODE_W +: CODE_W]
cfg_stop_code  in  NUM_CH*CODE_W  stop code, same packing
clear  in  1  single-cycle pulse; returns all channels to IDLE
rd_sel  in  $clog2(NUM_CH) (min 1)  readback channel select
rd_count  out  CNT_W  count of the selected channel
rd_state  out  2  state of the selected channel
busy  out  NUM_CH  channel in RUN
done  out  NUM_CH  channel in DONE
timeout  out  NUM_CH  channel in TOUT
irq  out  1  OR over i of (done[i] | timeout[i]) & cfg_enable[i]; level-sensitive

Behaviour:
- Reset: all sync and prev registers = 0; every channel in IDLE with count = 0 and sub = 0. Outputs busy, done, timeout, irq, rd_count and rd_state are all 0.
- Input path: checkbits passes through a 2-flop synchroniser (s1 -> s2), then a prev register.
- Event: ev = (s2 != prev). Code matching is evaluated only when ev = 1. A held code never re-triggers.
- Latency: a code change sampled at edge k is in s2 at k+1 and updates channel state at k+2.
- State encoding: IDLE=0, RUN=1, DONE=2, TOUT=3.
- Priority, highest first: reset > clear > !cfg_enable[i] (forces IDLE, zeroes count) > code match > timeout.
- IDLE: ev and s2 == start -> RUN, with count = 0 and sub = 0.
- RUN, counting:
  - sub increments each cycle.
  - When sub == PRESCALE-1, sub wraps to 0 and count increments.
  - count saturates at all-ones.
- RUN, events:
  - ev and s2 == stop -> DONE; count is frozen at the value held that cycle.
  - else ev and s2 == start -> restart: count = 0, sub = 0, stay in RUN.
  - If start == stop, stop wins while in RUN.
- RUN, timeout: TIMEOUT != 0 and count == TIMEOUT -> TOUT; count is held.
- DONE/TOUT: count is held. ev and s2 == start -> RUN (re-arm, zeroed). The stop code is ignored.
- Channel independence: channels are fully independent. One event may start or stop several channels in the same cycle.
- clear: takes effect at the next edge. It overrides a coincident code match.
- Readback: rd_count and rd_state are combinational muxes of the registered channel values. An out-of-range rd_sel returns 0.
- Timing example: a stop arriving N cycles after start yields count = floor((N-1)/PRESCALE), accounting for sub starting at 0 on the start edge.

Decomposition:
- Package perf_monitor_pkg: state typedef (IDLE/RUN/DONE/TOUT) and the 2-bit encoding constants.
- Sub-module perf_channel: one instance per channel, generated NUM_CH times. It holds the state machine, sub prescaler and count. Inputs are ev, code, start, stop, enable and clear.
- Top level holds the synchroniser, event detect, readback mux and irq reduction.

Test Plan:
1. Channel 0 start=0xA000, stop=0xAB00, PRESCALE=1000. Drive 0xA000, then 5000 cycles later 0xAB00 -> done[0]=1, rd_count=4 (per the floor formula), irq=1, busy[0]=0.
2. TIMEOUT=3, PRESCALE=10. Drive start and never stop -> timeout[0] asserts once count hits 3 (~30 cycles), rd_state=3, count stays at 3.
3. Drive start, wait 2500 cycles, re-drive start (via an intermediate code), wait 1000, then stop -> count reflects only the last segment (value 0 or 1 per the formula, not 3).
4. Ch0 start/stop = 0xA000/0xAB00, ch1 = 0xA000/0xAC00. Sequence A000, AB00, AC00 -> ch1 count >= ch0 count; both done.
5. Hold 0xA000 for 10 cycles, then pulse clear mid-RUN -> IDLE, count=0. Holding the code does not restart it; only a new change to 0xA000 does.
6. Assert reset during RUN -> all outputs 0 on the next edge. Deassert cfg_enable[1] while in DONE -> channel 1 goes to IDLE and irq drops.
